// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the 32-bit bus datapath: fetch (T0-T2), ALU execute (T3-T6), retire.
// Optional single-step mode under `define SEQ_STEP_EN (adds the step input and a PAUSE state after RETIRE).
module datapath_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int COUNT_W     = 16
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               run,
`ifdef SEQ_STEP_EN
   input  logic               step,
`endif
   input  logic               mem_ready,
   input  logic [31:0]        ir,
   output logic               pc_out,
   output logic               mar_in,
   output logic               inc_pc,
   output logic               read,
   output logic               mdr_in,
   output logic               mdr_out,
   output logic               ir_in,
   output logic               y_in,
   output logic [15:0]        reg_out,
   output logic [15:0]        reg_in,
   output logic [4:0]         alu_op,
   output logic               zhigh_in,
   output logic               zlow_in,
   output logic               zhigh_out,
   output logic               zlow_out,
   output logic               hi_in,
   output logic               lo_in,
   output logic               busy,
   output logic               halted,
   output logic               err,
   output logic [COUNT_W-1:0] instr_count
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_T0     = 4'd1;
   localparam logic [3:0] S_T1     = 4'd2;
   localparam logic [3:0] S_T2     = 4'd3;
   localparam logic [3:0] S_T3     = 4'd4;
   localparam logic [3:0] S_T4     = 4'd5;
   localparam logic [3:0] S_T5     = 4'd6;
   localparam logic [3:0] S_T6     = 4'd7;
   localparam logic [3:0] S_RETIRE = 4'd8;
   localparam logic [3:0] S_HALT   = 4'd9;
`ifdef SEQ_STEP_EN
   localparam logic [3:0] S_PAUSE  = 4'd10;
`endif

   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   logic [3:0]    state, next_state;
   logic [TW-1:0] tcnt;
   logic          set_err;
   logic          alu_class, is_muldiv, is_unary;
   logic [4:0]    opcode;
   logic [3:0]    ra, rb, rc;
   logic          unused_ir_bits;

   assign opcode         = ir[31:27];
   assign ra             = ir[26:23];
   assign rb             = ir[22:19];
   assign rc             = ir[18:15];
   assign unused_ir_bits = ^ir[14:0];
   assign is_muldiv      = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign is_unary       = (opcode == OP_NEG) || (opcode == OP_NOT);

   always_comb begin
      alu_class = 1'b0;
      case (opcode)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
         5'b01000, 5'b01111, 5'b10000, 5'b10001, 5'b10010: alu_class = 1'b1;
         default: alu_class = 1'b0;
      endcase
   end

   always_comb begin
      next_state = state;
      set_err    = 1'b0;
      case (state)
         S_IDLE: if (run) next_state = S_T0;
         S_T0:   next_state = S_T1;
         S_T1: begin
            if (mem_ready) next_state = S_T2;
            else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
               next_state = S_HALT;
               set_err    = 1'b1;
            end
         end
         S_T2:   next_state = S_T3;
         S_T3: begin
            if (alu_class)              next_state = S_T4;
            else if (opcode == OP_NOP)  next_state = S_RETIRE;
            else if (opcode == OP_HALT) next_state = S_HALT;
            else begin
               next_state = S_HALT;
               set_err    = 1'b1;
            end
         end
         S_T4:   next_state = S_T5;
         S_T5:   next_state = is_muldiv ? S_T6 : S_RETIRE;
         S_T6:   next_state = S_RETIRE;
`ifdef SEQ_STEP_EN
         S_RETIRE: next_state = run ? S_PAUSE : S_IDLE;
         S_PAUSE: begin
            if (!run)      next_state = S_IDLE;
            else if (step) next_state = S_T0;
         end
`else
         S_RETIRE: next_state = run ? S_T0 : S_IDLE;
`endif
         S_HALT: next_state = S_HALT;
         default: next_state = S_IDLE;
      endcase
   end

   // Outputs are decoded from next_state so each strobe is valid for the whole cycle of its state.
   // Note the T3 operand select is taken from ir as presented during T2.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state       <= S_IDLE;
         tcnt        <= '0;
         pc_out      <= 1'b0;
         mar_in      <= 1'b0;
         inc_pc      <= 1'b0;
         read        <= 1'b0;
         mdr_in      <= 1'b0;
         mdr_out     <= 1'b0;
         ir_in       <= 1'b0;
         y_in        <= 1'b0;
         reg_out     <= '0;
         reg_in      <= '0;
         alu_op      <= '0;
         zhigh_in    <= 1'b0;
         zlow_in     <= 1'b0;
         zhigh_out   <= 1'b0;
         zlow_out    <= 1'b0;
         hi_in       <= 1'b0;
         lo_in       <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= next_state;
         if (state == S_T1 && next_state == S_T1) tcnt <= tcnt + TW'(1);
         else                                     tcnt <= '0;

         pc_out    <= 1'b0;
         mar_in    <= 1'b0;
         inc_pc    <= 1'b0;
         read      <= 1'b0;
         mdr_in    <= 1'b0;
         mdr_out   <= 1'b0;
         ir_in     <= 1'b0;
         y_in      <= 1'b0;
         reg_out   <= '0;
         reg_in    <= '0;
         alu_op    <= '0;
         zhigh_in  <= 1'b0;
         zlow_in   <= 1'b0;
         zhigh_out <= 1'b0;
         zlow_out  <= 1'b0;
         hi_in     <= 1'b0;
         lo_in     <= 1'b0;
         busy      <= 1'b1;
         halted    <= 1'b0;

         case (next_state)
            S_IDLE: busy <= 1'b0;
            S_T0: begin
               pc_out <= 1'b1;
               mar_in <= 1'b1;
               inc_pc <= 1'b1;
            end
            S_T1: begin
               read   <= 1'b1;
               mdr_in <= 1'b1;
            end
            S_T2: begin
               mdr_out <= 1'b1;
               ir_in   <= 1'b1;
            end
            S_T3: begin
               reg_out <= 16'h0001 << rb;
               y_in    <= 1'b1;
            end
            S_T4: begin
               alu_op   <= opcode;
               zhigh_in <= 1'b1;
               zlow_in  <= 1'b1;
               reg_out  <= 16'h0001 << (is_unary ? rb : rc);
            end
            S_T5: begin
               zlow_out <= 1'b1;
               if (is_muldiv) lo_in  <= 1'b1;
               else           reg_in <= 16'h0001 << ra;
            end
            S_T6: begin
               zhigh_out <= 1'b1;
               hi_in     <= 1'b1;
            end
`ifdef SEQ_STEP_EN
            S_PAUSE: busy <= 1'b0;
`endif
            S_HALT: begin
               busy   <= 1'b0;
               halted <= 1'b1;
            end
            default: ;
         endcase

         if (set_err) err <= 1'b1;
         if (next_state == S_RETIRE) instr_count <= instr_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer (default build): fetch/execute strobes, memory wait/timeout, halts, abort.
module tb_datapath_sequencer;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        run = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] ir = 32'h0;
   logic        pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in;
   logic [15:0] reg_out, reg_in;
   logic [4:0]  alu_op;
   logic        zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
   logic        busy, halted, err;
   logic [15:0] instr_count;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   datapath_sequencer dut (
      .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
      .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .read(read),
      .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
      .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op),
      .zhigh_in(zhigh_in), .zlow_in(zlow_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
      .hi_in(hi_in), .lo_in(lo_in), .busy(busy), .halted(halted), .err(err),
      .instr_count(instr_count)
   );

   // Strobe bits, MSB first: pc_out mar_in inc_pc read mdr_in mdr_out ir_in y_in
   // zhigh_in zlow_in zhigh_out zlow_out hi_in lo_in, then alu_op, reg_out, reg_in.
   logic [50:0] obs;
   assign obs = {pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in,
                 zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, alu_op, reg_out, reg_in};

   localparam logic [13:0] B_T0   = 14'b11100000000000;
   localparam logic [13:0] B_T1   = 14'b00011000000000;
   localparam logic [13:0] B_T2   = 14'b00000110000000;
   localparam logic [13:0] B_T3   = 14'b00000001000000;
   localparam logic [13:0] B_T4   = 14'b00000000110000;
   localparam logic [13:0] B_T5   = 14'b00000000000100;
   localparam logic [13:0] B_T5MD = 14'b00000000000101;
   localparam logic [13:0] B_T6   = 14'b00000000001010;

   function automatic logic [50:0] mk(input logic [13:0] b, input logic [4:0] op,
                                      input logic [15:0] ro, input logic [15:0] ri);
      return {b, op, ro, ri};
   endfunction

   // Bus-driver exclusivity, every cycle.
   always @(negedge clock) begin
      checks++;
      if ($countones({pc_out, mdr_out, zhigh_out, zlow_out, reg_out}) > 1) begin
         failures++;
         $display("FAIL one_driver t=%0t: drivers=%b want at most one high", $time,
                  {pc_out, mdr_out, zhigh_out, zlow_out, reg_out});
      end
   end

   task automatic do_reset();
      clear = 1'b1;
      run = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      run = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (obs !== 51'h0 || busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0 ||
          instr_count !== 16'h0 || dut.state !== 4'd0) begin
         failures++;
         $display("FAIL reset: strobes=%h busy=%b halted=%b err=%b count=%h state=%h want all zero",
                  obs, busy, halted, err, instr_count, dut.state);
      end
      run = 1'b0;
      clear = 1'b0;
   endtask

   task automatic test_add();
      logic [50:0] exp_s [7];
      exp_s[0] = mk(B_T0, 5'd0, 16'h0, 16'h0);
      exp_s[1] = mk(B_T1, 5'd0, 16'h0, 16'h0);
      exp_s[2] = mk(B_T2, 5'd0, 16'h0, 16'h0);
      exp_s[3] = mk(B_T3, 5'd0, 16'h0004, 16'h0);
      exp_s[4] = mk(B_T4, 5'b00011, 16'h0008, 16'h0);
      exp_s[5] = mk(B_T5, 5'd0, 16'h0, 16'h0002);
      exp_s[6] = 51'h0;
      do_reset();
      ir = 32'h18918000;
      mem_ready = 1'b1;
      run = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clock);
         checks++;
         if (obs !== exp_s[c] || busy !== 1'b1) begin
            failures++;
            $display("FAIL add_step%0d: strobes=%h busy=%b want %h busy=1", c, obs, busy, exp_s[c]);
         end
      end
      checks++;
      if (instr_count !== 16'd1) begin
         failures++;
         $display("FAIL add_count: got %0d want 1", instr_count);
      end
      run = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || obs !== 51'h0 || instr_count !== 16'd1) begin
         failures++;
         $display("FAIL add_idle: busy=%b strobes=%h count=%0d want 0/0/1", busy, obs, instr_count);
      end
   endtask

   task automatic test_mul();
      logic [50:0] exp_s [8];
      exp_s[0] = mk(B_T0, 5'd0, 16'h0, 16'h0);
      exp_s[1] = mk(B_T1, 5'd0, 16'h0, 16'h0);
      exp_s[2] = mk(B_T2, 5'd0, 16'h0, 16'h0);
      exp_s[3] = mk(B_T3, 5'd0, 16'h0020, 16'h0);
      exp_s[4] = mk(B_T4, 5'b01111, 16'h0040, 16'h0);
      exp_s[5] = mk(B_T5MD, 5'd0, 16'h0, 16'h0);
      exp_s[6] = mk(B_T6, 5'd0, 16'h0, 16'h0);
      exp_s[7] = 51'h0;
      do_reset();
      ir = {5'b01111, 4'd4, 4'd5, 4'd6, 15'd0};
      mem_ready = 1'b1;
      run = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         checks++;
         if (obs !== exp_s[c]) begin
            failures++;
            $display("FAIL mul_step%0d: strobes=%h want %h", c, obs, exp_s[c]);
         end
      end
      checks++;
      if (instr_count !== 16'd1) begin
         failures++;
         $display("FAIL mul_count: got %0d want 1", instr_count);
      end
      run = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_mem_wait();
      int reads = 0;
      do_reset();
      ir = 32'h18918000;
      mem_ready = 1'b0;
      run = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         if (read === 1'b1 && mdr_in === 1'b1) reads++;
         if (c == 5) mem_ready = 1'b1;
      end
      checks++;
      if (reads != 4 || mdr_out !== 1'b1 || ir_in !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL mem_wait: read_cycles=%0d mdr_out=%b ir_in=%b err=%b want 4/1/1/0",
                  reads, mdr_out, ir_in, err);
      end
      run = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic test_timeout();
      int reads = 0;
      int halt_at = -1;
      do_reset();
      ir = 32'h18918000;
      mem_ready = 1'b0;
      run = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (read === 1'b1) reads++;
         if (halted === 1'b1 && halt_at < 0) halt_at = c;
      end
      checks++;
      if (reads != 15 || halt_at != 17) begin
         failures++;
         $display("FAIL timeout_len: read_cycles=%0d halt_cycle=%0d want 15/17", reads, halt_at);
      end
      checks++;
      if (err !== 1'b1 || halted !== 1'b1 || busy !== 1'b0 || obs !== 51'h0 || instr_count !== 16'd0) begin
         failures++;
         $display("FAIL timeout_state: err=%b halted=%b busy=%b strobes=%h count=%0d want 1/1/0/0/0",
                  err, halted, busy, obs, instr_count);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      ir = {5'b11111, 27'd0};
      mem_ready = 1'b1;
      run = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (obs !== mk(B_T3, 5'd0, 16'h0001, 16'h0) || halted !== 1'b0) begin
         failures++;
         $display("FAIL illegal_t3: strobes=%h halted=%b want %h halted=0", obs, halted,
                  mk(B_T3, 5'd0, 16'h0001, 16'h0));
      end
      repeat (3) @(negedge clock);
      checks++;
      if (err !== 1'b1 || halted !== 1'b1 || busy !== 1'b0 || obs !== 51'h0 || instr_count !== 16'd0) begin
         failures++;
         $display("FAIL illegal_halt: err=%b halted=%b busy=%b strobes=%h count=%0d want 1/1/0/0/0",
                  err, halted, busy, obs, instr_count);
      end
   endtask

   task automatic test_halt_op();
      do_reset();
      ir = {5'b11011, 27'd0};
      mem_ready = 1'b1;
      run = 1'b1;
      repeat (5) @(negedge clock);
      checks++;
      if (halted !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || instr_count !== 16'd0) begin
         failures++;
         $display("FAIL halt_op: halted=%b err=%b busy=%b count=%0d want 1/0/0/0",
                  halted, err, busy, instr_count);
      end
   endtask

   task automatic test_nop();
      do_reset();
      ir = {5'b11010, 27'd0};
      mem_ready = 1'b1;
      run = 1'b1;
      repeat (5) @(negedge clock);
      checks++;
      if (obs !== 51'h0 || busy !== 1'b1 || instr_count !== 16'd1) begin
         failures++;
         $display("FAIL nop_retire: strobes=%h busy=%b count=%0d want 0/1/1", obs, busy, instr_count);
      end
      run = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL nop_idle: busy=%b halted=%b want 0/0", busy, halted);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ir = 32'h18918000;
      mem_ready = 1'b1;
      run = 1'b1;
      repeat (8) @(negedge clock);
      checks++;
      if (obs !== mk(B_T0, 5'd0, 16'h0, 16'h0) || instr_count !== 16'd1) begin
         failures++;
         $display("FAIL b2b_refetch: strobes=%h count=%0d want T0 strobes, count 1", obs, instr_count);
      end
      repeat (6) @(negedge clock);
      checks++;
      if (instr_count !== 16'd2 || obs !== 51'h0) begin
         failures++;
         $display("FAIL b2b_second: count=%0d strobes=%h want 2/0", instr_count, obs);
      end
   endtask

   task automatic test_clear_mid();
      do_reset();
      ir = 32'h18918000;
      mem_ready = 1'b1;
      run = 1'b1;
      repeat (12) @(negedge clock);
      checks++;
      if (obs !== mk(B_T4, 5'b00011, 16'h0008, 16'h0) || instr_count !== 16'd1) begin
         failures++;
         $display("FAIL clear_pre: strobes=%h count=%0d want second-instr T4, count 1", obs, instr_count);
      end
      clear = 1'b1;
      #1;
      checks++;
      if (obs !== 51'h0 || busy !== 1'b0 || instr_count !== 16'd0 || dut.state !== 4'd0) begin
         failures++;
         $display("FAIL clear_async: strobes=%h busy=%b count=%0d state=%h want all zero",
                  obs, busy, instr_count, dut.state);
      end
      run = 1'b0;
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      checks++;
      if (obs !== 51'h0 || busy !== 1'b0 || err !== 1'b0 || instr_count !== 16'd0) begin
         failures++;
         $display("FAIL clear_after: strobes=%h busy=%b err=%b count=%0d want all zero",
                  obs, busy, err, instr_count);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_mem_wait();
      test_timeout();
      test_illegal();
      test_halt_op();
      test_nop();
      test_back_to_back();
      test_clear_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
